fft_bin_unloader: RTL and testbench
===================================

// Module: fft_bin_unloader
// PURPOSE
//  Output-side counterpart of the butterfly stages: captures one frame of N packed complex FFT bins
//  (parallel bus, bit-reversed storage order) and streams them out one bin per transfer in natural
//  bin order over a valid/ready interface, with a |re|+|im| magnitude tag. Sits between the last
//  butterfly column and any serial consumer (UART/host readout, peak detector).
// PARAMETERS
//  N       32  bins per frame; power of two
//  LOGN    5   log2(N); width of bin index
//  DW      16  packed complex width: imag[DW-1:DW/2], real[DW/2-1:0], each two's complement
//  BITREV  1   1: input position p holds bin bitrev(p); 0: input already in natural order
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        async active-low reset
//  load       in   1        1-cycle frame-capture request; honoured only when busy=0
//  bins_in    in   N*DW     frame; position p at bins_in[p*DW +: DW]
//  busy       out  1        frame held / streaming; load ignored while 1
//  out_valid  out  1        out_data/out_index/out_mag/out_last valid
//  out_ready  in   1        consumer accepts current bin
//  out_data   out  DW       packed complex bin, natural order
//  out_index  out  LOGN     bin number k of out_data
//  out_mag    out  DW/2+1   |re|+|im|, unsigned
//  out_last   out  1        high with bin N-1
// BEHAVIOUR
//  - Reset (async assert, sync deassert at use): state=IDLE; busy, out_valid, out_last=0;
//    out_data, out_index, out_mag=0; frame store cleared to 0.
//  - States: IDLE, STREAM. Transfer = out_valid && out_ready.
//  - IDLE: load=1 at edge t -> whole bins_in copied into frame store, state=STREAM, busy=1,
//    out_valid=1 with bin k=0 registered at edge t (visible cycle t+1). Latency load->first bin: 1.
//  - STREAM: out_data = store[BITREV ? bitrev_LOGN(k) : k]; out_index=k; out_last=(k==N-1).
//    On transfer with k<N-1: k<=k+1, outputs update next edge (one bin/cycle at full throughput).
//    On transfer with k==N-1: state=IDLE, busy=0, out_valid=0, out_last=0; out_data/index/mag hold.
//  - out_valid && !out_ready: all out_* held stable; out_valid never drops until transfer.
//  - load while busy: ignored, no effect on store or stream. load in the cycle the last bin
//    transfers: ignored (busy still 1); next frame needs load with busy=0.
//  - bins_in sampled only at the capture edge; may change freely afterwards.
//  - Magnitude: re,im sign-extended to DW/2+1, absolute value each (|-128|=128), summed mod 2^(DW/2+1);
//    max 128+128=256 fits 9 bits for DW=16, no overflow. Registered alongside out_data.
//  - k counter LOGN bits, no wrap past N-1 (exit to IDLE instead).
//  - rst_n low mid-frame: stream aborted immediately, reset values, remaining bins discarded.
// TESTING
//  1 Reset: rst_n=0 mid-STREAM -> out_valid=0, busy=0, out_data=0 same cycle; load after release works.
//  2 Ramp: position p = {8'h00, p}, BITREV=1, out_ready=1 -> 32 consecutive transfers, out_index 0..31,
//    out_data real = bitrev5(k) (k=1 -> 8'h10, k=3 -> 8'h18), out_last only at k=31, busy=0 after.
//  3 Backpressure: out_ready toggled 1,0,0,1 pseudo-random -> no bin dropped/duplicated, out_* stable
//    while stalled; sequence identical to test 2.
//  4 Magnitude: bin {8'h80,8'h80} -> out_mag=256; {8'hFF,8'h01} -> 2; {8'h05,8'hFD} -> 8; 0 -> 0.
//  5 Overlapping load: load pulses with new frame at k=5 and at last transfer -> ignored, stream
//    continues with old frame; load one cycle after busy=0 -> new frame bin 0 next cycle.
//  6 BITREV=0 build: same ramp -> out_data real = k for all k.

Source files
------------

// File: rtl/fft_bin_unloader.sv
// Captures one frame of packed complex FFT bins and streams them out in natural bin
// order over valid/ready, tagging each bin with an |re|+|im| magnitude.
module fft_bin_unloader #(
   parameter int N      = 32,
   parameter int LOGN   = 5,
   parameter int DW     = 16,
   parameter int BITREV = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [N*DW-1:0]   bins_in,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic [LOGN-1:0]   out_index,
   output logic [DW/2:0]     out_mag,
   output logic              out_last
);
   // state  | meaning
   // IDLE   | no frame held; waiting for load
   // STREAM | frame held; presenting bin out_index until it transfers

   localparam int HW = DW / 2;
   localparam int MW = HW + 1;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t            state;
   logic [N*DW-1:0]   store;
   logic [LOGN-1:0]   k_next;
   logic [DW-1:0]     next_bin;

   function automatic logic [LOGN-1:0] store_pos(input logic [LOGN-1:0] k);
      logic [LOGN-1:0] r;
      r = k;
      if (BITREV != 0) begin
         for (int i = 0; i < LOGN; i++) r[i] = k[LOGN-1-i];
      end
      return r;
   endfunction

   // One extra bit per component so |-2^(HW-1)| is representable.
   function automatic logic [MW-1:0] mag_of(input logic [DW-1:0] b);
      logic [MW-1:0] re;
      logic [MW-1:0] im;
      re = {b[HW-1], b[HW-1:0]};
      im = {b[DW-1], b[DW-1:HW]};
      if (re[MW-1]) re = -re;
      if (im[MW-1]) im = -im;
      return re + im;
   endfunction

   always_comb begin
      k_next   = out_index + 1'b1;
      next_bin = store[int'(store_pos(k_next))*DW +: DW];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         store     <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
         out_mag   <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  // bit-reverse of index 0 is 0, so bin 0 always sits at position 0
                  store     <= bins_in;
                  state     <= STREAM;
                  busy      <= 1'b1;
                  out_valid <= 1'b1;
                  out_data  <= bins_in[DW-1:0];
                  out_index <= '0;
                  out_mag   <= mag_of(bins_in[DW-1:0]);
                  out_last  <= (N == 1);
               end
            end
            STREAM: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end else begin
                     out_index <= k_next;
                     out_data  <= next_bin;
                     out_mag   <= mag_of(next_bin);
                     out_last  <= (k_next == LOGN'(N - 1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_bin_unloader.sv
// Bench for fft_bin_unloader: bit-reversed and natural-order builds side by side,
// checked every cycle against a frame-level model of the bin stream.
module tb_fft_bin_unloader;
   localparam int N    = 32;
   localparam int LOGN = 5;
   localparam int DW   = 16;
   localparam int HW   = DW / 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              load = 1'b0;
   logic              out_ready = 1'b0;
   logic [N*DW-1:0]   bins_in = '0;

   logic              busy1, valid1, last1, busy0, valid0, last0;
   logic [DW-1:0]     data1, data0;
   logic [LOGN-1:0]   idx1, idx0;
   logic [HW:0]       mag1, mag0;

   int checks = 0;
   int errors = 0;

   fft_bin_unloader #(.N(N), .LOGN(LOGN), .DW(DW), .BITREV(1)) u1 (
      .clk(clk), .rst_n(rst_n), .load(load), .bins_in(bins_in), .busy(busy1),
      .out_valid(valid1), .out_ready(out_ready), .out_data(data1), .out_index(idx1),
      .out_mag(mag1), .out_last(last1));

   fft_bin_unloader #(.N(N), .LOGN(LOGN), .DW(DW), .BITREV(0)) u0 (
      .clk(clk), .rst_n(rst_n), .load(load), .bins_in(bins_in), .busy(busy0),
      .out_valid(valid0), .out_ready(out_ready), .out_data(data0), .out_index(idx0),
      .out_mag(mag0), .out_last(last0));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int brev(input int k);
      int r = 0;
      for (int i = 0; i < LOGN; i++) if ((k >> i) & 1) r += 1 << (LOGN - 1 - i);
      return r;
   endfunction

   function automatic int mag_of(input logic [DW-1:0] b);
      int re, im;
      re = int'($signed(b[HW-1:0]));
      im = int'($signed(b[DW-1:HW]));
      if (re < 0) re = -re;
      if (im < 0) im = -im;
      return (re + im) % (1 << (HW + 1));
   endfunction

   // Model: which frame is held, which bin is on offer, whether any frame was ever shown.
   logic [DW-1:0] mframe [N];
   bit mbusy = 0;
   bit mever = 0;
   int mk = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mbusy = 0; mever = 0; mk = 0;
      end else if (!mbusy) begin
         if (load) begin
            for (int p = 0; p < N; p++) mframe[p] = bins_in[p*DW +: DW];
            mbusy = 1; mever = 1; mk = 0;
         end
      end else if (out_ready) begin
         if (mk == N - 1) mbusy = 0;
         else mk++;
      end
   end

   bit pin_ramp = 0;
   bit pin_mag = 0;
   int beats = 0;
   bit prev_stall = 0;
   logic [DW-1:0] prev_data;
   logic [LOGN-1:0] prev_idx;

   always @(negedge clk) begin
      logic [DW-1:0] e1, e0;
      e1 = mever ? mframe[brev(mk)] : '0;
      e0 = mever ? mframe[mk] : '0;
      chk("busy", busy1, mbusy);
      chk("out_valid", valid1, mbusy);
      chk("out_last", last1, mbusy && mk == N - 1);
      chk("out_index", idx1, mever ? mk : 0);
      chk("out_data", data1, e1);
      chk("out_mag", mag1, mag_of(e1));
      chk("nat_valid", valid0, mbusy);
      chk("nat_data", data0, e0);
      chk("nat_mag", mag0, mag_of(e0));
      if (prev_stall && rst_n) begin
         chk("stall_data", data1, prev_data);
         chk("stall_index", idx1, prev_idx);
      end
      if (pin_ramp && valid1) begin
         if (idx1 == 1) chk("ramp_k1", data1, 32'h0010);
         if (idx1 == 3) chk("ramp_k3", data1, 32'h0018);
         chk("ramp_nat", data0, {24'h0, 3'b000, idx0});
      end
      if (pin_mag && valid0) begin
         case (idx0)
            5'd0: chk("mag_8080", mag0, 256);
            5'd1: chk("mag_ff01", mag0, 2);
            5'd2: chk("mag_05fd", mag0, 8);
            5'd3: chk("mag_zero", mag0, 0);
            default: ;
         endcase
      end
      if (valid1 && out_ready) beats++;
      prev_stall = valid1 && !out_ready;
      prev_data  = data1;
      prev_idx   = idx1;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_ramp();
      for (int p = 0; p < N; p++) bins_in[p*DW +: DW] = {8'h00, 8'(p)};
   endtask

   task automatic set_random();
      for (int p = 0; p < N; p++) bins_in[p*DW +: DW] = DW'($urandom);
   endtask

   task automatic start_frame();
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   // rmode 0: ready held high; 1: random ready
   task automatic drain(input int rmode, input string nm);
      int n = 0;
      while (busy1 && n < 400) begin
         out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         step();
         n++;
      end
      chk(nm, n < 400, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      chk("rst_busy", busy1, 0);
      chk("rst_data", data1, 0);

      // Ramp at full throughput
      set_ramp(); pin_ramp = 1; beats = 0;
      start_frame();
      chk("ramp_latency", valid1, 1);
      drain(0, "ramp_timeout");
      chk("ramp_beats", beats, 32);
      chk("ramp_idle", busy1, 0);

      // Same ramp under random backpressure
      beats = 0;
      start_frame();
      drain(1, "bp_timeout");
      chk("bp_beats", beats, 32);
      pin_ramp = 0;

      // Magnitude corner bins (natural-order instance)
      bins_in = '0;
      bins_in[0*DW +: DW] = 16'h8080;
      bins_in[1*DW +: DW] = 16'hFF01;
      bins_in[2*DW +: DW] = 16'h05FD;
      pin_mag = 1;
      start_frame();
      drain(1, "mag_timeout");
      pin_mag = 0;

      // Loads while busy, including on the final transfer, are ignored
      set_ramp(); pin_ramp = 1;
      start_frame();
      begin
         int n = 0;
         out_ready = 1'b1;
         while (busy1 && n < 100) begin
            load = valid1 && (idx1 == 5 || last1);
            set_random();
            step();
            n++;
         end
         load = 1'b0;
         chk("ovl_timeout", n < 100, 1);
      end
      pin_ramp = 0;
      set_random();
      start_frame();
      chk("reload_busy", busy1, 1);
      chk("reload_index", idx1, 0);
      drain(1, "reload_timeout");

      // Random frames with random backpressure
      for (int f = 0; f < 4; f++) begin
         set_random();
         start_frame();
         drain(1, "rand_timeout");
      end

      // Asynchronous reset in the middle of a stream
      set_random();
      start_frame();
      out_ready = 1'b1;
      repeat (6) step();
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", valid1, 0);
      chk("arst_busy", busy1, 0);
      chk("arst_data", data1, 0);
      chk("arst_nat_data", data0, 0);
      step();
      rst_n = 1'b1;
      step();
      set_random();
      start_frame();
      chk("post_rst_valid", valid1, 1);
      drain(1, "post_rst_timeout");

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
